nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
- Multi-cycle controller that feeds the team's 4-bit ripple adder one nibble pair per cycle and consumes its sum and carry-out.
- Chains carry through a register, producing NIBBLES*4-bit add/subtract results, LS nibble first.
- Sits directly upstream and downstream of the 4-bit adder: it drives A, B and carry-in, and registers S and carry-out.
- Valid/ready handshake on both the input and output streams.

Parameters:
- NIBBLES, 4: nibbles per operation (operand width = 4*NIBBLES). Legal range is 2..16.
- CW, 4: width of the nibble counter. Must satisfy 2^CW >= NIBBLES.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin an operation; sampled only in IDLE
- op_sub  input  1  sampled with start: 0 = A+B, 1 = A-B
- in_valid  input  1  a_nib/b_nib valid
- in_ready  output  1  block accepts a nibble pair this cycle
- a_nib  input  4  operand A nibble, LS nibble first
- b_nib  input  4  operand B nibble, LS nibble first
- out_valid  output  1  s_nib valid
- out_ready  input  1  consumer accepts s_nib this cycle
- s_nib  output  4  result nibble
- last  output  1  s_nib is the final (MS) nibble
- carry_out  output  1  final carry; valid only when last=1
- overflow  output  1  signed overflow; valid only when last=1
- busy  output  1  high from start accepted until final nibble accepted

Behaviour:
- Interface decision: one clock (clk); asynchronous active-low reset (rst_n).
- Reset values: state=IDLE, in_ready=0, out_valid=0, s_nib=0, last=0, carry_out=0, overflow=0, busy=0. Internal carry register=0, counter=0, sub flag=0.
- States: IDLE, RUN, DRAIN.
- IDLE: in_ready=0, busy=0. On start=1: latch op_sub into the sub flag, set carry register=op_sub, counter=0, go to RUN. busy=1 from the next cycle.
- RUN: in_ready = !out_valid || out_ready (one-deep output register).
- Accept in RUN (in_valid && in_ready):
  - Adder inputs are A=a_nib, B=b_nib XOR {4{sub}}, carry-in=carry register.
  - The 4-bit adder is the existing _4bAdder or a bit-identical inline add.
  - Next edge: s_nib=S, out_valid=1, carry register=C3, counter+1.
  - last = (counter==NIBBLES-1).
- Final nibble accept: also register carry_out=C3 and overflow=(A[3] ~^ B'[3]) & (S[3] ^ A[3]), where B' is the post-XOR operand. Go to DRAIN.
- Subtract: carry_out=1 means no borrow.
- DRAIN: in_ready=0. When out_valid && out_ready: out_valid=0, last=0, go to IDLE.
- Output handshake:
  - Output accepted when out_valid && out_ready. out_valid drops the same edge unless a new nibble loads the same edge.
  - s_nib, last, carry_out and overflow are stable while out_valid=1 and out_ready=0.
- Latency and throughput: result nibble appears 1 cycle after its input is accepted. Throughput is 1 nibble/cycle while out_ready=1.
- Simultaneous events:
  - Output accept and new input accept in the same cycle: register reloads, out_valid stays 1.
  - start while state!=IDLE: ignored, and op_sub is not re-sampled.
- Idle inputs: in_valid in IDLE or DRAIN is ignored; no nibble is consumed.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). The partial result is discarded; no last is emitted.
- carry_out and overflow hold their value until the next final-nibble load. They are only meaningful when last=1.

Test Plan:
- Add, NIBBLES=4: start, op_sub=0; feed A=0x1234, B=0x0FCD as nibble pairs (4,D),(3,C),(2,F),(1,0) with out_ready=1 -> s_nib stream 1,0,2,2 (0x2201), last on 4th nibble, carry_out=0, overflow=0, busy low 1 cycle after 4th accept.
- Subtract: op_sub=1, A=0x0005, B=0x0007 -> 0xFFFE (nibbles E,F,F,F), carry_out=0 (borrow), overflow=0.
- Boundaries:
  - 0x7FFF+0x0001 -> 0x8000, carry_out=0, overflow=1.
  - 0xFFFF+0x0001 -> 0x0000, carry_out=1, overflow=0.
  - 0x8000-0x0001 -> 0x7FFF, overflow=1, carry_out=1.
- Backpressure: hold out_ready=0 with in_valid=1 -> exactly one nibble accepted, then in_ready=0 and s_nib/last stable. Release out_ready -> in_ready=1 the same cycle, no nibble lost or duplicated, final result matches the add case.
- Control hazards:
  - Pulse start with op_sub=1 during RUN -> ignored; the operation completes as an add.
  - Assert rst_n=0 after 2 nibbles -> out_valid=0 and busy=0 immediately.
  - A fresh operation after reset produces a correct result with carry-in=op_sub.

Source files
------------

// File: rtl/nibble_serial_adder_if.sv
// Control, input-stream and output-stream signals of the nibble-serial adder.
// The slave modport is the adder itself; master is whoever drives and consumes it.
interface nibble_serial_adder_if;
  logic       start;
  logic       op_sub;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] s_nib;
  logic       last;
  logic       carry_out;
  logic       overflow;
  logic       busy;

  modport master (
    output start, op_sub, in_valid, a_nib, b_nib, out_ready,
    input  in_ready, out_valid, s_nib, last, carry_out, overflow, busy
  );

  modport slave (
    input  start, op_sub, in_valid, a_nib, b_nib, out_ready,
    output in_ready, out_valid, s_nib, last, carry_out, overflow, busy
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-nibble add/subtract built around a 4-bit ripple adder, LS nibble first,
// with the carry chained through a register and a one-deep output register.
module nibble_serial_adder #(
  parameter int NIBBLES = 4,
  parameter int CW      = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  nibble_serial_adder_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          carry_reg, carry_next;
  logic          sub_reg, sub_next;
  logic          out_valid_reg, out_valid_next;
  logic [3:0]    s_nib_reg, s_nib_next;
  logic          last_reg, last_next;
  logic          carry_out_reg, carry_out_next;
  logic          overflow_reg, overflow_next;

  logic [3:0] b_eff;
  logic [3:0] sum;
  logic [4:0] c;
  logic       ovf;
  logic       is_last;
  logic       in_ready;
  logic       in_fire;
  logic       out_fire;

  // Subtraction is A + ~B + 1: the +1 comes from the carry register seeded with op_sub.
  assign b_eff = bus.b_nib ^ {4{sub_reg}};
  assign c[0]  = carry_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_ripple
    assign sum[gi]  = bus.a_nib[gi] ^ b_eff[gi] ^ c[gi];
    assign c[gi+1]  = (bus.a_nib[gi] & b_eff[gi]) | (c[gi] & (bus.a_nib[gi] ^ b_eff[gi]));
  end

  assign ovf     = (bus.a_nib[3] ~^ b_eff[3]) & (sum[3] ^ bus.a_nib[3]);
  assign is_last = (cnt_reg == CW'(NIBBLES - 1));

  assign in_ready = (state_reg == RUN) && (!out_valid_reg || bus.out_ready);
  assign in_fire  = bus.in_valid && in_ready;
  assign out_fire = out_valid_reg && bus.out_ready;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    carry_next     = carry_reg;
    sub_next       = sub_reg;
    out_valid_next = out_valid_reg;
    s_nib_next     = s_nib_reg;
    last_next      = last_reg;
    carry_out_next = carry_out_reg;
    overflow_next  = overflow_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          sub_next   = bus.op_sub;
          carry_next = bus.op_sub;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        if (out_fire) out_valid_next = 1'b0;
        // A load in the same cycle as an output accept overrides the drop.
        if (in_fire) begin
          s_nib_next     = sum;
          out_valid_next = 1'b1;
          carry_next     = c[4];
          cnt_next       = cnt_reg + CW'(1);
          last_next      = is_last;
          if (is_last) begin
            carry_out_next = c[4];
            overflow_next  = ovf;
            state_next     = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_fire) begin
          out_valid_next = 1'b0;
          last_next      = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      carry_reg     <= 1'b0;
      sub_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      s_nib_reg     <= 4'h0;
      last_reg      <= 1'b0;
      carry_out_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      carry_reg     <= carry_next;
      sub_reg       <= sub_next;
      out_valid_reg <= out_valid_next;
      s_nib_reg     <= s_nib_next;
      last_reg      <= last_next;
      carry_out_reg <= carry_out_next;
      overflow_reg  <= overflow_next;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.s_nib     = s_nib_reg;
  assign bus.last      = last_reg;
  assign bus.carry_out = carry_out_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench: directed vector table, hand-written hazard sequences and
// randomized operations checked against an arithmetic reference model.
module tb_nibble_serial_adder;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  nibble_serial_adder_if bus ();

  nibble_serial_adder #(.NIBBLES(N), .CW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] s;
    logic         c;
    logic         v;
    int           hold;
    logic         glitch;
    string        name;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: whole-word integer arithmetic, signed range test for overflow.
  task automatic ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                           output logic [W-1:0] s, output logic c, output logic v);
    longint ua, ub, sa, sb, r;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= (64'sd1 << (W-1))) ? ua - (64'sd1 << W) : ua;
    sb = (ub >= (64'sd1 << (W-1))) ? ub - (64'sd1 << W) : ub;
    if (sub) begin
      s = W'(ua - ub);
      c = (ua >= ub);
      r = sa - sb;
    end else begin
      s = W'(ua + ub);
      c = ((ua + ub) >> W) != 0;
      r = sa + sb;
    end
    v = (r > ((64'sd1 << (W-1)) - 1)) || (r < -(64'sd1 << (W-1)));
  endtask

  // Runs one operation; optional output stall for the first `hold` cycles,
  // a stray start pulse in RUN, or random valid/ready patterns.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input int hold, input logic glitch, input logic rnd,
                       input logic [W-1:0] exp_s, input logic exp_c, input logic exp_v,
                       input string name);
    int idx_in, out_cnt, cyc;
    logic iv, prev_stall, prev_last, got_c, got_v;
    logic [3:0] prev_s;
    logic [W-1:0] res;
    idx_in = 0; out_cnt = 0; cyc = 0; prev_stall = 0; prev_last = 0; prev_s = 0;
    res = '0; got_c = 0; got_v = 0;

    @(negedge clk);
    bus.start = 1'b1; bus.op_sub = sub; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.op_sub = 1'b0;
    #1 check({name, "_busy_start"}, 32'(bus.busy), 32'd1);

    while (out_cnt < N && cyc < 400) begin
      iv = (idx_in < N) ? (rnd ? ($urandom_range(0, 3) != 0) : 1'b1) : 1'b0;
      bus.in_valid  = iv;
      bus.a_nib     = 4'(a >> (4 * idx_in));
      bus.b_nib     = 4'(b >> (4 * idx_in));
      bus.out_ready = (cyc < hold) ? 1'b0 : (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
      bus.start     = glitch && (cyc == 1);
      bus.op_sub    = glitch && (cyc == 1);
      #1;
      if (prev_stall) begin
        check({name, "_stall_valid"}, 32'(bus.out_valid), 32'd1);
        check({name, "_stall_s_nib"}, 32'(bus.s_nib), 32'(prev_s));
        check({name, "_stall_last"}, 32'(bus.last), 32'(prev_last));
      end
      if (hold > 0 && cyc == hold) begin
        check({name, "_bp_accepted"}, 32'(idx_in), 32'd1);
        check({name, "_bp_release_ready"}, 32'(bus.in_ready), 32'd1);
      end
      if (bus.out_valid && !bus.out_ready)
        check({name, "_stall_in_ready"}, 32'(bus.in_ready), 32'd0);
      if (iv && bus.in_ready) idx_in++;
      if (bus.out_valid && bus.out_ready) begin
        res = res | (W'(bus.s_nib) << (4 * out_cnt));
        check({name, "_last_pos"}, 32'(bus.last), 32'(out_cnt == N - 1));
        if (out_cnt == N - 1) begin
          got_c = bus.carry_out;
          got_v = bus.overflow;
        end
        out_cnt++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_s     = bus.s_nib;
      prev_last  = bus.last;
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0; bus.start = 1'b0; bus.op_sub = 1'b0; bus.out_ready = 1'b1;
    if (out_cnt < N) check({name, "_timeout"}, 32'(out_cnt), 32'(N));
    #1;
    check({name, "_sum"}, 32'(res), 32'(exp_s));
    check({name, "_carry"}, 32'(got_c), 32'(exp_c));
    check({name, "_ovf"}, 32'(got_v), 32'(exp_v));
    check({name, "_busy_end"}, 32'(bus.busy), 32'd0);
    $display("op %s a=%h b=%h sub=%0d -> s=%h c=%0d v=%0d", name, a, b, sub, res, got_c, got_v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb, es;
    logic rs, ec, ev;
    checks = 0; errors = 0;

    vecs[0] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 0, 1'b0, "add"};
    vecs[1] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0, 1'b0, "sub_borrow"};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1'b0, "add_ovf"};
    vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, "add_wrap"};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0, 1'b0, "sub_ovf"};
    vecs[5] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 4, 1'b0, "backpressure"};
    vecs[6] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 0, 1'b1, "start_in_run"};

    bus.start = 0; bus.op_sub = 0; bus.in_valid = 0; bus.a_nib = 0; bus.b_nib = 0;
    bus.out_ready = 1;
    rst_n = 1'b0;
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_s_nib", 32'(bus.s_nib), 32'd0);
    check("rst_last", 32'(bus.last), 32'd0);
    check("rst_carry_out", 32'(bus.carry_out), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Input in IDLE must be ignored.
    @(negedge clk);
    bus.in_valid = 1'b1;
    #1 check("idle_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check("idle_no_output", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b0;

    for (int i = 0; i < 7; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].hold, vecs[i].glitch, 1'b0,
            vecs[i].s, vecs[i].c, vecs[i].v, vecs[i].name);

    // Reset after two nibbles, then a fresh subtract relying on carry-in = op_sub.
    @(negedge clk);
    bus.start = 1'b1; bus.op_sub = 1'b0;
    @(negedge clk);
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.a_nib = 4'h4; bus.b_nib = 4'hD;
    @(negedge clk);
    bus.a_nib = 4'h3; bus.b_nib = 4'hC;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 check("midop_valid_before_rst", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midop_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midop_rst_busy", 32'(bus.busy), 32'd0);
    check("midop_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("midop_rst_last", 32'(bus.last), 32'd0);
    $display("reset mid-operation applied");
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h0005, 16'h0007, 1'b1, 0, 1'b0, 1'b0, 16'hFFFE, 1'b0, 1'b0, "after_reset_sub");

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      if (i % 8 == 0) rb = ra;
      ref_model(ra, rb, rs, es, ec, ev);
      do_op(ra, rb, rs, 0, 1'b0, 1'b1, es, ec, ev, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
